// File: rtl/ikaopll_bus_writer.sv
// Host-side write sequencer for the OPLL bus pins.
// Queues {register address, data} commands in a small FIFO and replays each one
// as an address write followed by a data write, each with its mandatory busy
// wait. All bus timing advances only on phiM ticks (i_phiM_PCEN_n low).
//
// Handshake: a command is accepted on any clock where i_CMD_VALID and
// o_CMD_READY are both high; o_CMD_READY is simply "FIFO not full" and does
// not depend on i_CMD_VALID.
//
// The bus outputs are registered from the FSM state, so they show a state's
// bus shape one tick after the FSM enters it. A push into an empty idle writer
// therefore pops on the first tick and drives CS_n low on the second.
module ikaopll_bus_writer #(
   parameter int FIFO_AW        = 3,
   parameter int STRB_LEN       = 2,
   parameter int ADDR_WAIT      = 12,
   parameter int DATA_WAIT      = 84,
   parameter int SKIP_SAME_ADDR = 1
) (
   input  logic               i_EMUCLK,
   input  logic               i_RST_n,
   input  logic               i_phiM_PCEN_n,
   input  logic               i_CMD_VALID,
   output logic               o_CMD_READY,
   input  logic [7:0]         i_CMD_ADDR,
   input  logic [7:0]         i_CMD_DATA,
   output logic               o_CS_n,
   output logic               o_WR_n,
   output logic               o_A0,
   output logic [7:0]         o_D,
   output logic               o_BUSY,
   output logic [FIFO_AW:0]   o_LEVEL
);

   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int MAXAD  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int MAXW   = (MAXAD > STRB_LEN) ? MAXAD : STRB_LEN;
   localparam int CW     = $clog2(MAXW + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_A_SET,
      S_A_STRB,
      S_A_HOLD,
      S_A_WAIT,
      S_D_SET,
      S_D_STRB,
      S_D_HOLD,
      S_D_WAIT
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [15:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [FIFO_AW:0]   level_q;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [15:0]        head;

   assign full  = (level_q == (FIFO_AW+1)'(DEPTH));
   assign empty = (level_q == '0);
   assign push  = i_CMD_VALID & ~full;
   assign head  = mem_q[rd_ptr_q];

   // Storage array; contents need no reset because level_q gates every read.
   always_ff @(posedge i_EMUCLK) begin
      if (push) mem_q[wr_ptr_q] <= {i_CMD_ADDR, i_CMD_DATA};
   end

   // Pointers and occupancy; pushes happen on any clock, pops only on ticks.
   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t          state_q, state_d, nxt;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            tick;
   logic            advance;
   logic            dispatch;
   logic            skip;
   logic [7:0]      cur_addr_q, cur_data_q;
   logic [7:0]      last_addr_q;
   logic            last_valid_q;

   assign tick = ~i_phiM_PCEN_n;
   assign skip = (SKIP_SAME_ADDR != 0) && last_valid_q && (head[15:8] == last_addr_q);

   // Number of ticks spent in a state; zero means the state is skipped.
   function automatic logic [CW-1:0] dur(input state_t s);
      case (s)
         S_IDLE:             dur = '0;
         S_A_STRB, S_D_STRB: dur = CW'(STRB_LEN);
         S_A_WAIT:           dur = CW'(ADDR_WAIT);
         S_D_WAIT:           dur = CW'(DATA_WAIT);
         default:            dur = CW'(1);
      endcase
   endfunction

   // Next state: count down inside a state, then step along the write sequence;
   // the end of a data write (or IDLE) dispatches the next FIFO command.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      nxt      = state_q;
      advance  = 1'b0;
      dispatch = 1'b0;
      pop      = 1'b0;
      if (tick) begin
         if (state_q == S_IDLE)      dispatch = 1'b1;
         else if (cnt_q > CW'(1))    cnt_d    = cnt_q - 1'b1;
         else                        advance  = 1'b1;
      end
      if (advance) begin
         case (state_q)
            S_A_SET:  nxt = S_A_STRB;
            S_A_STRB: nxt = S_A_HOLD;
            S_A_HOLD: nxt = (ADDR_WAIT > 0) ? S_A_WAIT : S_D_SET;
            S_A_WAIT: nxt = S_D_SET;
            S_D_SET:  nxt = S_D_STRB;
            S_D_STRB: nxt = S_D_HOLD;
            S_D_HOLD: begin
               if (DATA_WAIT > 0) nxt = S_D_WAIT;
               else               dispatch = 1'b1;
            end
            default:  dispatch = 1'b1;
         endcase
      end
      if (dispatch) begin
         if (empty) begin
            nxt = S_IDLE;
         end else begin
            pop = 1'b1;
            nxt = skip ? S_D_SET : S_A_SET;
         end
      end
      if (advance || dispatch) begin
         state_d = nxt;
         cnt_d   = dur(nxt);
      end
   end

   // State, counter, current command, last address and registered bus pins.
   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cur_addr_q   <= '0;
         cur_data_q   <= '0;
         last_addr_q  <= '0;
         last_valid_q <= 1'b0;
         o_CS_n       <= 1'b1;
         o_WR_n       <= 1'b1;
         o_A0         <= 1'b0;
         o_D          <= '0;
      end else if (tick) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (pop) begin
            cur_addr_q <= head[15:8];
            cur_data_q <= head[7:0];
         end
         // A_HOLD always lasts one tick, so every tick spent in it is its exit.
         if (state_q == S_A_HOLD) begin
            last_addr_q  <= cur_addr_q;
            last_valid_q <= 1'b1;
         end
         case (state_q)
            S_A_SET: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b1;
               o_A0   <= 1'b0;
               o_D    <= cur_addr_q;
            end
            S_D_SET: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b1;
               o_A0   <= 1'b1;
               o_D    <= cur_data_q;
            end
            S_A_STRB, S_D_STRB: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b0;
            end
            S_A_HOLD, S_D_HOLD: begin
               o_CS_n <= 1'b0;
               o_WR_n <= 1'b1;
            end
            default: begin
               o_CS_n <= 1'b1;
               o_WR_n <= 1'b1;
            end
         endcase
      end
   end

   assign o_CMD_READY = ~full;
   assign o_LEVEL     = level_q;
   assign o_BUSY      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Bench for ikaopll_bus_writer: a timeline model turns every popped command
// into its list of per-tick bus shapes and is compared with the DUT on every
// clock, with directed scenarios pinned by literal counts and write orders.
module tb_ikaopll_bus_writer;
  localparam int STRB_LEN  = 2;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pcen_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       ready, cs_n, wr_n, a0, busy;
  logic [7:0] d;
  logic [3:0] level;

  ikaopll_bus_writer dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_phiM_PCEN_n (pcen_n),
    .i_CMD_VALID   (valid),
    .o_CMD_READY   (ready),
    .i_CMD_ADDR    (addr),
    .i_CMD_DATA    (data),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d),
    .o_BUSY        (busy),
    .o_LEVEL       (level)
  );

  // ---------------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // pcen modes: 0 always tick, 1 never tick, 2 one tick in four, 3 random
  int pcen_mode = 0;
  int pcen_cyc  = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      pcen_cyc++;
      case (pcen_mode)
        0: pcen_n = 1'b0;
        1: pcen_n = 1'b1;
        2: pcen_n = ((pcen_cyc % 4) == 0) ? 1'b0 : 1'b1;
        default: pcen_n = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------------------------------------------------------- model
  // segment = {fsm_active_on_bus, cs_n, wr_n, a0, d}; bit 11 low = bus idle
  logic [15:0] m_fifo[$];
  logic [11:0] m_sched[$];
  logic [11:0] m_cur = 12'h0;
  bit          m_cur_valid = 1'b0;
  logic [7:0]  m_last_addr = 8'h00;
  bit          m_last_valid = 1'b0;
  logic        e_cs = 1'b1, e_wr = 1'b1, e_a0 = 1'b0;
  logic [7:0]  e_d = 8'h00;

  task automatic add_phase(input logic phase_a0, input logic [7:0] v, input int wait_ticks);
    m_sched.push_back({1'b1, 1'b0, 1'b1, phase_a0, v});
    for (int i = 0; i < STRB_LEN; i++) m_sched.push_back({1'b1, 1'b0, 1'b0, phase_a0, v});
    m_sched.push_back({1'b1, 1'b0, 1'b1, phase_a0, v});
    for (int i = 0; i < wait_ticks; i++) m_sched.push_back(12'h0);
  endtask

  task automatic build_cmd(input logic [15:0] c);
    if (!(m_last_valid && c[15:8] == m_last_addr)) begin
      add_phase(1'b0, c[15:8], ADDR_WAIT);
      m_last_addr  = c[15:8];
      m_last_valid = 1'b1;
    end
    add_phase(1'b1, c[7:0], DATA_WAIT);
  endtask

  initial begin
    logic tick_now;
    logic acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        m_sched.delete();
        m_cur_valid  = 1'b0;
        m_last_valid = 1'b0;
        e_cs = 1'b1; e_wr = 1'b1; e_a0 = 1'b0; e_d = 8'h00;
      end else begin
        tick_now = !pcen_n;
        acc = valid && (m_fifo.size() < 8);
        if (tick_now) begin
          if (m_cur_valid && m_cur[11]) {e_cs, e_wr, e_a0, e_d} = m_cur[10:0];
          else begin
            e_cs = 1'b1;
            e_wr = 1'b1;
          end
          if (m_sched.size() > 0) begin
            m_cur = m_sched.pop_front();
          end else if (m_fifo.size() > 0) begin
            build_cmd(m_fifo.pop_front());
            m_cur = m_sched.pop_front();
            m_cur_valid = 1'b1;
          end else begin
            m_cur_valid = 1'b0;
          end
        end
        if (acc) m_fifo.push_back({addr, data});
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard / monitor
  int mon_busy = 0, mon_csa = 0, mon_wra = 0, mon_csd = 0, mon_wrd = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wlog[$];
  logic prev_wr = 1'b1;

  always @(negedge clk) begin
    chk("cs_n",  cs_n,  e_cs);
    chk("wr_n",  wr_n,  e_wr);
    chk("a0",    a0,    e_a0);
    chk("d",     d,     e_d);
    chk("busy",  busy,  m_cur_valid || (m_fifo.size() != 0));
    chk("level", level, m_fifo.size());
    chk("ready", ready, m_fifo.size() < 8);
    if (busy) mon_busy++;
    if (!cs_n && !a0) mon_csa++;
    if (!wr_n && !a0) mon_wra++;
    if (!cs_n && a0)  mon_csd++;
    if (!wr_n && a0)  mon_wrd++;
    if (prev_wr && !wr_n && a0) wlog.push_back(d);
    prev_wr = wr_n;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic mon_clear();
    mon_busy = 0; mon_csa = 0; mon_wra = 0; mon_csd = 0; mon_wrd = 0;
    wlog.delete();
    exp_q.delete();
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] v);
    valid = 1'b1; addr = a; data = v;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_clk, input string name);
    int n = 0;
    while (busy && n < max_clk) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk({name, "_data"}, wlog[i], exp_q[i]);
  endtask

  // ---------------------------------------------------------------- scenarios
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs_n, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_level", level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // single full write
    mon_clear();
    push_cmd(8'h10, 8'h55);
    wait_idle(300, "t1");
    chk("t1_busy_clocks", mon_busy, 105);
    chk("t1_cs_addr", mon_csa, 4);
    chk("t1_wr_addr", mon_wra, 2);
    chk("t1_cs_data", mon_csd, 4);
    chk("t1_wr_data", mon_wrd, 2);
    exp_q.push_back(8'h55);
    check_log("t1");

    // same address twice: second write skips the address phase
    mon_clear();
    push_cmd(8'h20, 8'h01);
    push_cmd(8'h20, 8'h02);
    wait_idle(400, "t2");
    chk("t2_busy_clocks", mon_busy, 193);
    chk("t2_cs_addr", mon_csa, 4);
    chk("t2_cs_data", mon_csd, 8);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    check_log("t2");

    // fill with ticks frozen; the ninth command is refused
    mon_clear();
    pcen_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      push_cmd(8'h30 + 8'(i), 8'hA0 + 8'(i));
      if (i < 8) exp_q.push_back(8'hA0 + 8'(i));
    end
    @(negedge clk);
    chk("t3_level_full", level, 8);
    chk("t3_ready_low", ready, 1'b0);
    @(posedge clk); #1;
    pcen_mode = 0;
    wait_idle(1200, "t3");
    check_log("t3");

    // reset in the middle of a data strobe
    push_cmd(8'h44, 8'h99);
    begin
      int n = 0;
      while (!(wr_n == 1'b0 && a0 == 1'b1) && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t4_reach_dstrb", n < 300, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_wr", wr_n, 1'b1);
    chk("t4_rst_cs", cs_n, 1'b1);
    chk("t4_rst_level", level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_clear();
    push_cmd(8'h44, 8'h77);
    wait_idle(300, "t4");
    chk("t4_cs_addr_full", mon_csa, 4);
    exp_q.push_back(8'h77);
    check_log("t4");

    // one tick in four: every phase stretches by four clocks
    mon_clear();
    pcen_mode = 2;
    push_cmd(8'h50, 8'h5A);
    wait_idle(600, "t5");
    chk("t5_cs_addr", mon_csa, 16);
    chk("t5_wr_addr", mon_wra, 8);
    chk("t5_cs_data", mon_csd, 16);
    chk("t5_wr_data", mon_wrd, 8);

    // simultaneous push and pop at level 3
    mon_clear();
    pcen_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      push_cmd(8'h60 + 8'(i), 8'hC0 + 8'(i));
      exp_q.push_back(8'hC0 + 8'(i));
    end
    @(negedge clk);
    chk("t6_level3", level, 3);
    @(posedge clk); #1;
    pcen_mode = 0;
    push_cmd(8'h63, 8'hC3);
    exp_q.push_back(8'hC3);
    @(negedge clk);
    chk("t6_level_kept", level, 3);
    @(posedge clk); #1;
    wait_idle(600, "t6");
    check_log("t6");

    // random traffic, random tick density, occasional reset
    pcen_mode = 3;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        valid = 1'b0;
      end else begin
        rst_n = 1'b1;
        valid = ($urandom_range(0, 9) < 3);
        addr  = 8'($urandom_range(0, 3));
        data  = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    rst_n = 1'b1;
    pcen_mode = 0;
    wait_idle(1200, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
